// File: rtl/ps2_kb_receiver_pkg.sv
// Purpose: shared PS/2 receiver definitions (deframer state encoding, frame constants).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_kb_receiver_pkg;

    // Deframer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;  // break (key release) prefix
    localparam logic [7:0] PS2_EXT        = 8'hE0;  // extended-key prefix, reported as a normal code
    localparam int         PS2_FRAME_BITS = 11;     // start + 8 data + parity + stop

endpackage

// File: rtl/ps2_clk_filter.sv
// Purpose: 2-FF synchroniser, FILTER_LEN-sample glitch filter and falling-edge detect for ps2_clk.
// Latency: fall is high in the cycle after posedge FILTER_LEN+3, counted from the first posedge seeing the pin fall.
// Backpressure: none; free-running front end.
//
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   raw_in    asynchronous PS/2 clock pin (idles high)
//   filt      registered filtered level
//   fall      one-cycle pulse when filt goes 1 -> 0
module ps2_clk_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic filt,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] stages;
    logic                  filt_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            stages    <= '1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            sync      <= {sync[0], raw_in};
            stages    <= {stages[FILTER_LEN-2:0], sync[1]};
            // The filtered level only moves once every stage agrees; otherwise it holds.
            if (&stages) begin
                filt <= 1'b1;
            end else if (~|stages) begin
                filt <= 1'b0;
            end
            filt_prev <= filt;
        end
    end

    assign fall = filt_prev & ~filt;

endmodule

// File: rtl/ps2_kb_receiver.sv
// Purpose: PS/2 keyboard receiver; deframes 11-bit frames, checks parity/stop, holds last good scan code.
// Latency: kb_valid is high in the cycle after posedge FILTER_LEN+4, counted from the first posedge seeing the stop-bit clock fall.
// Backpressure: none; kb_code is held until the next accepted code and may be sampled at any time.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   ps2_clk    raw PS/2 clock pin, ps2_data raw PS/2 data pin (both asynchronous, idle high)
//   kb_code    last accepted scan code
//   kb_valid   one-cycle pulse when kb_code updates
//   kb_err     one-cycle pulse on parity, stop-bit or timeout error
// Optional feature: define KB_BREAK_FILTER_EN to swallow the F0 break prefix and the code that follows it.
module ps2_kb_receiver
    import ps2_kb_receiver_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [BUS_WIDTH-1:0] kb_code,
    output logic                 kb_valid,
    output logic                 kb_err
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int               BC_W    = $clog2(BUS_WIDTH);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BUS_WIDTH - 1);

    logic                 clk_filt;
    logic                 clk_fall;
    logic                 bit_edge;
    logic [1:0]           data_sync;
    logic                 data_bit;
    ps2_state_t           state;
    logic [BC_W-1:0]      bitcnt;
    logic [BUS_WIDTH-1:0] sr;
    logic                 par_bit;
    logic [TO_W-1:0]      to_cnt;
`ifdef KB_BREAK_FILTER_EN
    logic                 break_pending;
`endif

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .raw_in (ps2_clk),
        .filt   (clk_filt),
        .fall   (clk_fall)
    );

    // Bit edges are taken only while the filtered clock is low.
    assign bit_edge = clk_fall & ~clk_filt;
    assign data_bit = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync <= 2'b11;
            state     <= ST_IDLE;
            bitcnt    <= '0;
            sr        <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            kb_code   <= '0;
            kb_valid  <= 1'b0;
            kb_err    <= 1'b0;
`ifdef KB_BREAK_FILTER_EN
            break_pending <= 1'b0;
`endif
        end else begin
            data_sync <= {data_sync[0], ps2_data};
            kb_valid  <= 1'b0;
            kb_err    <= 1'b0;

            // Timeout only runs mid-frame; a clock fall always restarts it, even on the expiry cycle.
            if (state == ST_IDLE || bit_edge) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (bit_edge) begin
                case (state)
                    ST_IDLE: begin
                        // A high data line here is a spurious edge, silently ignored.
                        if (!data_bit) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        sr     <= {data_bit, sr[BUS_WIDTH-1:1]};
                        bitcnt <= bitcnt + BC_W'(1);
                        if (bitcnt == BC_LAST) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_bit;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (data_bit && (^{sr, par_bit})) begin
`ifdef KB_BREAK_FILTER_EN
                            // F0 arms the filter; the following good frame is consumed silently.
                            if (break_pending) begin
                                break_pending <= 1'b0;
                            end else if (sr == PS2_BREAK) begin
                                break_pending <= 1'b1;
                            end else begin
                                kb_code  <= sr;
                                kb_valid <= 1'b1;
                            end
`else
                            kb_code  <= sr;
                            kb_valid <= 1'b1;
`endif
                        end else begin
                            kb_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
                state  <= ST_IDLE;
                kb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kb_receiver.sv
`timescale 1ns/1ps
module tb_ps2_kb_receiver;

    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;   // PS/2 half-period in clk cycles (1 us clk -> 20 us)
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kb_code;
    logic       kb_valid;
    logic       kb_err;

    ps2_kb_receiver #(
        .BUS_WIDTH      (8),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb_code  (kb_code),
        .kb_valid (kb_valid),
        .kb_err   (kb_err)
    );

    always #500 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   valid_cnt = 0;
    int   err_cnt   = 0;
    int   last_valid_cyc = 0;
    logic rst_q = 1'b1;
    logic [7:0] prev_code = 8'h00;
    logic [7:0] seen[$];

    // Reference model state: what the keyboard port should hold.
    logic [7:0] m_code  = 8'h00;
    logic       m_break = 1'b0;

    typedef struct {
        logic [7:0] code;
        logic       par;
        logic       stop;
        logic       exp_v;
        logic       exp_e;
        logic [7:0] exp_code;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Output monitor: counts pulses and checks the always-true output rules.
    always @(negedge clk) begin
        if (!rst_q) begin
            if (kb_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                seen.push_back(kb_code);
            end
            if (kb_err) err_cnt++;
            if (kb_valid || kb_err) chk("valid_err_overlap", 32'(kb_valid & kb_err), 0);
            if (kb_code !== prev_code) chk("code_change_without_valid", 32'(kb_valid), 1);
        end
        prev_code = kb_code;
    end

    // Frame outcome from the protocol rules: odd parity over data+parity, stop must be 1.
    task automatic model_frame(input logic [7:0] code, input logic par, input logic stop,
                               output logic ev, output logic ee);
        bit good;
        good = stop && (($countones({code, par}) % 2) == 1);
        ev = 1'b0;
        ee = !good;
        if (good) begin
`ifdef KB_BREAK_FILTER_EN
            if (m_break) m_break = 1'b0;
            else if (code == 8'hF0) m_break = 1'b1;
            else begin ev = 1'b1; m_code = code; end
`else
            ev = 1'b1;
            m_code = code;
`endif
        end
    endtask

    // Drive the first nbits of an LSB-first frame; data is set at the start of each high phase.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch,
                             output int stop_cyc);
        stop_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            if (i == glitch) begin
                repeat (HALF / 2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic run_frame(input string nm, input logic [7:0] code, input logic par,
                             input logic stop, input int glitch, input logic ev,
                             input logic ee, input logic [7:0] ec);
        int v0, e0, sc;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits({stop, par, code, 1'b0}, 11, glitch, sc);
        repeat (GAP) @(negedge clk);
        chk({nm, "_valid_pulses"}, valid_cnt - v0, 32'(ev));
        chk({nm, "_err_pulses"}, err_cnt - e0, 32'(ee));
        chk({nm, "_kb_code"}, 32'(kb_code), 32'(ec));
        if (ev) chk({nm, "_latency"}, last_valid_cyc - sc, FL + 4);
    endtask

    task automatic model_run(input string nm, input logic [7:0] code, input logic par,
                             input logic stop, input int glitch);
        logic ev, ee;
        model_frame(code, par, stop, ev, ee);
        run_frame(nm, code, par, stop, glitch, ev, ee, m_code);
    endtask

    initial begin
        int v0, e0, sc;
        logic [7:0] c;
        logic p, s;

        //                code   par   stop  v     e     code
        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};  // good 1C
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};  // parity error
        tbl[2] = '{8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};  // stop error
        tbl[3] = '{8'h32, 1'b0, 1'b1, 1'b1, 1'b0, 8'h32};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[6] = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE0};  // extended prefix reported
        tbl[7] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hE0};
        tbl[8] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_kb_code", 32'(kb_code), 0);
        chk("reset_kb_valid", 32'(kb_valid), 0);
        chk("reset_kb_err", 32'(kb_err), 0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].code, tbl[i].par, tbl[i].stop, -1,
                      tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_code);
            m_code = tbl[i].exp_code;
        end

        // Short clock glitch mid-data must not add a bit.
        model_run("glitch", 8'h32, 1'b0, 1'b1, 4);

        // Partial frame then silence: one timeout error, code held, FSM ready again.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, -1, sc);
        repeat (TO + 60) @(negedge clk);
        chk("timeout_err_pulses", err_cnt - e0, 1);
        chk("timeout_valid_pulses", valid_cnt - v0, 0);
        chk("timeout_kb_code", 32'(kb_code), 32'(m_code));
        model_run("after_timeout", 8'h32, 1'b0, 1'b1, -1);

        // Reset after the 5th data bit.
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 6, -1, sc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_kb_code", 32'(kb_code), 0);
        chk("midreset_kb_valid", 32'(kb_valid), 0);
        chk("midreset_kb_err", 32'(kb_err), 0);
        m_code = 8'h00;
        m_break = 1'b0;
        repeat (10) @(negedge clk);
        model_run("after_reset", 8'h5A, 1'b1, 1'b1, -1);

        // Break-prefix sequence F0,1C,1C.
        seen.delete();
        model_run("brk_f0", 8'hF0, 1'b1, 1'b1, -1);
        model_run("brk_1c_a", 8'h1C, 1'b0, 1'b1, -1);
        model_run("brk_1c_b", 8'h1C, 1'b0, 1'b1, -1);
`ifdef KB_BREAK_FILTER_EN
        chk("brk_seq_count", seen.size(), 1);
        if (seen.size() == 1) chk("brk_seq_code0", 32'(seen[0]), 32'h1C);
`else
        chk("brk_seq_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("brk_seq_code0", 32'(seen[0]), 32'hF0);
            chk("brk_seq_code1", 32'(seen[1]), 32'h1C);
            chk("brk_seq_code2", 32'(seen[2]), 32'h1C);
        end
`endif

        // Randomised frames against the model.
        for (int i = 0; i < 25; i++) begin
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) c = 8'hF0;
            p = ~(^c);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 7) != 0);
            model_run($sformatf("rnd%0d", i), c, p, s, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
